// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stage indices, stop levels,
// FSM encodings and the stall-mask helper.
package pipe_ctrl_pkg;

    localparam int unsigned NumStages = 5;

    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;
    localparam logic BranchEnable = 1'b1;

    localparam int unsigned StagePc    = 0;
    localparam int unsigned StageIfId  = 1;
    localparam int unsigned StageIdEx  = 2;
    localparam int unsigned StageExMem = 3;
    localparam int unsigned StageMemWb = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StDrain = 2'b01,
        StEnter = 2'b10
    } state_e;

    // A stall from a given stage holds that stage and everything upstream of it.
    function automatic logic [NumStages-1:0] stall_mask(input logic req_if, input logic req_id,
                                                        input logic req_ex, input logic req_mem);
        logic [NumStages-1:0] mask;
        mask = {NumStages{NoStop}};
        if (req_mem) begin
            mask[StageMemWb:StagePc] = {5{Stop}};
        end else if (req_ex) begin
            mask[StageExMem:StagePc] = {4{Stop}};
        end else if (req_id) begin
            mask[StageIdEx:StagePc] = {3{Stop}};
        end else if (req_if) begin
            mask[StageIfId:StagePc] = {2{Stop}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/pipe_ctrl_watchdog.sv
// Saturating consecutive-stall counter with a registered timeout flag.
module stall_watchdog #(
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic timeout
);

    localparam logic [7:0] LimitCnt = 8'(STALL_LIMIT);

    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q;

    always_comb begin
        cnt_d = cnt_q;
        if (!stall) begin
            cnt_d = '0;
        end else if (cnt_q < LimitCnt) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= (cnt_d == LimitCnt);
        end
    end

    assign timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall masks, branch redirect and trap entry
// (drain the back end, then flush and redirect to the latched vector).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stallreq_if_i,
    input  logic                 stallreq_id_i,
    input  logic                 stallreq_ex_i,
    input  logic                 stallreq_mem_i,
    input  logic                 branch_flag_i,
    input  logic [XLEN-1:0]      branch_addr_i,
    input  logic                 trap_req_i,
    input  logic [XLEN-1:0]      trap_vector_i,
    output logic [NumStages-1:0] stalled_o,
    output logic                 flush_o,
    output logic                 redirect_o,
    output logic [XLEN-1:0]      redirect_pc_o,
    output logic                 trap_ack_o,
    output logic                 stall_timeout_o
);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   vec_q, vec_d;

    always_comb begin
        state_d       = state_q;
        vec_d         = vec_q;
        stalled_o     = stall_mask(stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
        flush_o       = 1'b0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        trap_ack_o    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A trap request outranks a branch resolved in the same cycle.
                if (trap_req_i) begin
                    state_d = StDrain;
                    vec_d   = trap_vector_i;
                end else if (branch_flag_i == BranchEnable) begin
                    flush_o       = 1'b1;
                    redirect_o    = 1'b1;
                    redirect_pc_o = branch_addr_i;
                end
            end
            StDrain: begin
                // Freeze the front end while older instructions retire.
                stalled_o[StageIfId:StagePc] = {2{Stop}};
                if (!stallreq_mem_i && !stallreq_ex_i) begin
                    state_d = StEnter;
                end
            end
            StEnter: begin
                flush_o       = 1'b1;
                redirect_o    = 1'b1;
                redirect_pc_o = vec_q;
                trap_ack_o    = 1'b1;
                state_d       = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

    stall_watchdog #(
        .STALL_LIMIT(STALL_LIMIT)
    ) u_stall_watchdog (
        .clk    (clk),
        .rst    (rst),
        .stall  (stalled_o[StagePc]),
        .timeout(stall_timeout_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int unsigned Limit = 4;

    logic        clk;
    logic        rst;
    logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
    logic        branch_flag_i;
    logic [31:0] branch_addr_i;
    logic        trap_req_i;
    logic [31:0] trap_vector_i;
    logic [4:0]  stalled_o;
    logic        flush_o, redirect_o, trap_ack_o, stall_timeout_o;
    logic [31:0] redirect_pc_o;

    int checks = 0;
    int passes = 0;

    pipe_ctrl #(
        .XLEN       (32),
        .STALL_LIMIT(Limit)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_if_i  (stallreq_if_i),
        .stallreq_id_i  (stallreq_id_i),
        .stallreq_ex_i  (stallreq_ex_i),
        .stallreq_mem_i (stallreq_mem_i),
        .branch_flag_i  (branch_flag_i),
        .branch_addr_i  (branch_addr_i),
        .trap_req_i     (trap_req_i),
        .trap_vector_i  (trap_vector_i),
        .stalled_o      (stalled_o),
        .flush_o        (flush_o),
        .redirect_o     (redirect_o),
        .redirect_pc_o  (redirect_pc_o),
        .trap_ack_o     (trap_ack_o),
        .stall_timeout_o(stall_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: inputs change just after the rising edge, outputs sampled 2ns later.
    // sreq is {mem, ex, id, if}.
    task automatic drive(input logic [3:0] sreq, input logic br, input logic [31:0] ba,
                         input logic tr, input logic [31:0] tv);
        @(posedge clk);
        #1;
        stallreq_mem_i = sreq[3];
        stallreq_ex_i  = sreq[2];
        stallreq_id_i  = sreq[1];
        stallreq_if_i  = sreq[0];
        branch_flag_i  = br;
        branch_addr_i  = ba;
        trap_req_i     = tr;
        trap_vector_i  = tv;
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        stallreq_if_i = 0; stallreq_id_i = 0; stallreq_ex_i = 0; stallreq_mem_i = 0;
        branch_flag_i = 0; branch_addr_i = '0; trap_req_i = 0; trap_vector_i = '0;
        #12;
        checks++; if (stalled_o !== 5'b00000)
            $display("FAIL reset_stalled: got %b want 00000", stalled_o); else passes++;
        checks++; if ({flush_o, redirect_o, trap_ack_o} !== 3'b000)
            $display("FAIL reset_ctrl: got %b want 000", {flush_o, redirect_o, trap_ack_o});
        else passes++;
        checks++; if (redirect_pc_o !== 32'h0)
            $display("FAIL reset_pc: got %h want 0", redirect_pc_o); else passes++;
        checks++; if (stall_timeout_o !== 1'b0)
            $display("FAIL reset_timeout: got %b want 0", stall_timeout_o); else passes++;
        rst = 1'b1;
    endtask

    task automatic test_stall_priority();
        logic [4:0] exp;
        int depth;
        drive(4'b0010, 0, 0, 0, 0);
        checks++; if (stalled_o !== 5'b00111)
            $display("FAIL id_only: got %b want 00111", stalled_o); else passes++;
        drive(4'b1010, 0, 0, 0, 0);
        checks++; if (stalled_o !== 5'b11111)
            $display("FAIL id_mem: got %b want 11111", stalled_o); else passes++;
        drive(4'b0000, 0, 0, 0, 0);
        checks++; if (stalled_o !== 5'b00000)
            $display("FAIL none: got %b want 00000", stalled_o); else passes++;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] r;
            r = 4'(i);
            depth = r[3] ? 5 : r[2] ? 4 : r[1] ? 3 : r[0] ? 2 : 0;
            exp = 5'((1 << depth) - 1);
            drive(r, 0, 0, 0, 0);
            checks++; if (stalled_o !== exp)
                $display("FAIL prio_%0d: got %b want %b", i, stalled_o, exp); else passes++;
        end
        drive(4'b0000, 0, 0, 0, 0);
    endtask

    task automatic test_branch();
        drive(4'b0000, 1, 32'h8000_0040, 0, 0);
        checks++; if ({flush_o, redirect_o} !== 2'b11)
            $display("FAIL branch_ctrl: got %b want 11", {flush_o, redirect_o}); else passes++;
        checks++; if (redirect_pc_o !== 32'h8000_0040)
            $display("FAIL branch_pc: got %h want 80000040", redirect_pc_o); else passes++;
        drive(4'b0000, 0, 32'h8000_0040, 0, 0);
        checks++; if ({flush_o, redirect_o, redirect_pc_o} !== 34'h0)
            $display("FAIL branch_after: got %b%b %h want 0 0 0", flush_o, redirect_o,
                     redirect_pc_o);
        else passes++;
    endtask

    task automatic test_trap_drain();
        drive(4'b1000, 0, 0, 1, 32'h8000_0100);
        checks++; if ({redirect_o, trap_ack_o} !== 2'b00)
            $display("FAIL trap_accept: got %b want 00", {redirect_o, trap_ack_o}); else passes++;
        drive(4'b1000, 0, 0, 1, 32'h8000_0100);
        checks++; if ({stalled_o, trap_ack_o} !== 6'b111110)
            $display("FAIL drain1: got %b want 111110", {stalled_o, trap_ack_o}); else passes++;
        drive(4'b1000, 1, 32'h0000_0bad, 1, 32'h8000_0100);
        checks++; if ({redirect_o, flush_o, trap_ack_o} !== 3'b000)
            $display("FAIL drain2_branch: got %b want 000", {redirect_o, flush_o, trap_ack_o});
        else passes++;
        drive(4'b0000, 0, 0, 1, 32'h8000_0100);
        checks++; if ({stalled_o, trap_ack_o} !== 6'b000110)
            $display("FAIL drain3: got %b want 000110", {stalled_o, trap_ack_o}); else passes++;
        drive(4'b0000, 0, 0, 1, 32'h8000_0100);
        checks++; if ({flush_o, redirect_o, trap_ack_o} !== 3'b111)
            $display("FAIL enter_ctrl: got %b want 111", {flush_o, redirect_o, trap_ack_o});
        else passes++;
        checks++; if (redirect_pc_o !== 32'h8000_0100)
            $display("FAIL enter_pc: got %h want 80000100", redirect_pc_o); else passes++;
        drive(4'b0000, 0, 0, 0, 0);
        checks++; if ({stalled_o, flush_o, redirect_o, trap_ack_o} !== 8'h00)
            $display("FAIL post_enter: got %b want 00000000",
                     {stalled_o, flush_o, redirect_o, trap_ack_o});
        else passes++;
    endtask

    task automatic test_trap_vs_branch();
        drive(4'b0000, 1, 32'h0000_1234, 1, 32'hABCD_0000);
        checks++; if ({flush_o, redirect_o} !== 2'b00)
            $display("FAIL tvb_no_branch: got %b want 00", {flush_o, redirect_o}); else passes++;
        // Request withdrawn while draining: entry must still complete.
        drive(4'b0000, 0, 0, 0, 32'h1111_1111);
        checks++; if ({stalled_o, trap_ack_o} !== 6'b000110)
            $display("FAIL tvb_drain: got %b want 000110", {stalled_o, trap_ack_o}); else passes++;
        drive(4'b0000, 0, 0, 0, 32'h2222_2222);
        checks++; if ({trap_ack_o, redirect_pc_o} !== {1'b1, 32'hABCD_0000})
            $display("FAIL tvb_enter: got %b %h want 1 abcd0000", trap_ack_o, redirect_pc_o);
        else passes++;
        drive(4'b0000, 0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        drive(4'b0000, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            drive(4'b0100, 0, 0, 0, 0);
            checks++; if (stall_timeout_o !== (i >= 5))
                $display("FAIL timeout_c%0d: got %b want %b", i, stall_timeout_o, (i >= 5));
            else passes++;
        end
        drive(4'b0000, 0, 0, 0, 0);
        checks++; if (stall_timeout_o !== 1'b1)
            $display("FAIL timeout_release: got %b want 1", stall_timeout_o); else passes++;
        drive(4'b0000, 0, 0, 0, 0);
        checks++; if (stall_timeout_o !== 1'b0)
            $display("FAIL timeout_clear: got %b want 0", stall_timeout_o); else passes++;
    endtask

    task automatic test_reset_in_drain();
        drive(4'b1000, 0, 0, 1, 32'h8000_0200);
        drive(4'b1000, 0, 0, 1, 32'h8000_0200);
        drive(4'b1000, 0, 0, 1, 32'h8000_0200);
        #1;
        rst = 1'b0;
        stallreq_mem_i = 0; trap_req_i = 0; trap_vector_i = '0;
        #1;
        checks++; if ({stalled_o, flush_o, redirect_o, trap_ack_o, stall_timeout_o} !== 9'h0)
            $display("FAIL rst_drain_out: got %b want 000000000",
                     {stalled_o, flush_o, redirect_o, trap_ack_o, stall_timeout_o});
        else passes++;
        @(posedge clk);
        #2;
        checks++; if ({stalled_o, trap_ack_o} !== 6'b0)
            $display("FAIL rst_drain_hold: got %b want 000000", {stalled_o, trap_ack_o});
        else passes++;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(4'b0100, 0, 0, 0, 0);
            checks++; if ({trap_ack_o, stall_timeout_o} !== {1'b0, 1'(i >= 5)})
                $display("FAIL rst_cnt_c%0d: got %b want %b", i, {trap_ack_o, stall_timeout_o},
                         {1'b0, 1'(i >= 5)});
            else passes++;
        end
        drive(4'b0000, 0, 0, 0, 0);
        checks++; if ({stalled_o, trap_ack_o} !== 6'b0)
            $display("FAIL rst_idle: got %b want 000000", {stalled_o, trap_ack_o}); else passes++;
        drive(4'b0000, 0, 0, 0, 0);
        checks++; if (trap_ack_o !== 1'b0)
            $display("FAIL rst_no_ack: got %b want 0", trap_ack_o); else passes++;
    endtask

    task automatic test_random();
        bit          pending, entering, hold;
        logic [31:0] m_vec;
        int          run_len, depth;
        logic [3:0]  sreq;
        logic        br;
        logic [31:0] ba, tv;
        logic [4:0]  e_stall;
        logic        e_redir, e_ack;
        logic [31:0] e_pc;
        drive(4'b0000, 0, 0, 0, 0);
        pending = 0; entering = 0; hold = 0; m_vec = '0; run_len = 0;
        for (int n = 0; n < 300; n++) begin
            sreq = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            br = ($urandom_range(0, 3) == 0);
            ba = $urandom;
            tv = $urandom;
            if (!hold && $urandom_range(0, 9) == 0) hold = 1;
            else if (pending && $urandom_range(0, 7) == 0) hold = 0;
            drive(sreq, br, ba, hold, tv);

            depth = sreq[3] ? 5 : sreq[2] ? 4 : sreq[1] ? 3 : sreq[0] ? 2 : 0;
            e_stall = 5'((1 << depth) - 1);
            if (pending) e_stall = e_stall | 5'b00011;
            e_redir = 0; e_ack = 0; e_pc = '0;
            if (entering) begin
                e_redir = 1; e_ack = 1; e_pc = m_vec;
            end else if (!pending && !hold && br) begin
                e_redir = 1; e_pc = ba;
            end

            checks++; if (stalled_o !== e_stall)
                $display("FAIL rnd_stall@%0d: got %b want %b", n, stalled_o, e_stall);
            else passes++;
            checks++; if ({flush_o, redirect_o} !== {e_redir, e_redir})
                $display("FAIL rnd_redir@%0d: got %b want %b", n, {flush_o, redirect_o},
                         {e_redir, e_redir});
            else passes++;
            checks++; if (redirect_pc_o !== e_pc)
                $display("FAIL rnd_pc@%0d: got %h want %h", n, redirect_pc_o, e_pc);
            else passes++;
            checks++; if (trap_ack_o !== e_ack)
                $display("FAIL rnd_ack@%0d: got %b want %b", n, trap_ack_o, e_ack);
            else passes++;
            checks++; if (stall_timeout_o !== (run_len >= int'(Limit)))
                $display("FAIL rnd_timeout@%0d: got %b want %b", n, stall_timeout_o,
                         (run_len >= int'(Limit)));
            else passes++;

            if (entering) begin
                entering = 0;
                hold = 0;
            end else if (pending) begin
                if (!sreq[3] && !sreq[2]) begin
                    pending = 0;
                    entering = 1;
                end
            end else if (hold) begin
                pending = 1;
                m_vec = tv;
            end
            run_len = e_stall[0] ? run_len + 1 : 0;
        end
        drive(4'b0000, 0, 0, 0, 0);
        drive(4'b0000, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_stall_priority();
        test_branch();
        test_trap_drain();
        test_trap_vs_branch();
        test_timeout();
        test_reset_in_drain();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
